// File: rtl/packet_tagger_pkg.sv
// Shared types and helpers for the packet_tagger store-and-forward buffer.
// DISCARD state exists only when PACKET_TAGGER_DROP_EN is defined.
package packet_tagger_pkg;

    typedef enum logic [1:0] {
        ST_HEAD,
        ST_BODY
`ifdef PACKET_TAGGER_DROP_EN
        , ST_DISCARD
`endif
    } wr_state_t;

    // Pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [7:0] popcount(input logic [127:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 128; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/packet_tagger_ram.sv
// Simple dual-port beat buffer, one write port, one registered read port.
module packet_tagger_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/packet_tagger.sv
// Store-and-forward AXI-Stream buffer tagging packets with header ID and length.
// Define PACKET_TAGGER_DROP_EN to drop packets longer than MAX_BEATS.
module packet_tagger
    import packet_tagger_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 16,
    parameter int TID_WIDTH   = 16,
    parameter int TUSER_WIDTH = 16,
    parameter int ID_LSB      = 24,
    parameter int DATA_DEPTH  = 2048,
    parameter int DESC_DEPTH  = 16,
    parameter int COUNT_BYTES = 0,
    parameter int MAX_BEATS   = 1024,
    localparam int KW = TDATA_WIDTH / 8
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
`ifdef PACKET_TAGGER_DROP_EN
    output logic [31:0]            drop_count,
`endif
    input  logic [TDATA_WIDTH-1:0] in_TDATA,
    input  logic [TDEST_WIDTH-1:0] in_TDEST,
    input  logic [KW-1:0]          in_TKEEP,
    input  logic                   in_TLAST,
    input  logic                   in_TVALID,
    output logic                   in_TREADY,
    output logic [TDATA_WIDTH-1:0] out_TDATA,
    output logic [TDEST_WIDTH-1:0] out_TDEST,
    output logic [KW-1:0]          out_TKEEP,
    output logic                   out_TLAST,
    output logic                   out_TVALID,
    input  logic                   out_TREADY,
    output logic [TID_WIDTH-1:0]   out_TID,
    output logic [TUSER_WIDTH-1:0] out_TUSER
);

    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int PW  = ptr_w(DATA_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int DPW = ptr_w(DESC_DEPTH);
    localparam int RW  = TDATA_WIDTH + TDEST_WIDTH + KW + 1;
    localparam int DW  = TID_WIDTH + TUSER_WIDTH;
    localparam int LW  = TUSER_WIDTH + 9;
    localparam logic [TUSER_WIDTH-1:0] LEN_MAX = '1;

    if (MAX_BEATS > DATA_DEPTH) begin : g_bad_cfg
        $error("MAX_BEATS must not exceed DATA_DEPTH");
    end

    wr_state_t r_state, w_state_nx;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_commit;
    logic [DPW-1:0] r_dwr, r_drd;
    logic [DW-1:0] r_desc [DESC_DEPTH];
    logic [TID_WIDTH-1:0] r_id, w_id_nx;
    logic [TUSER_WIDTH-1:0] r_len, w_len_nx, w_base;
    logic [LW-1:0] w_sum;
    logic [7:0] w_inc;
    logic r_run, r_rd_vld;
    logic w_beat, w_we, w_push, w_pop, w_pop_desc, w_issue;
    logic w_data_full, w_desc_full, w_desc_empty;
    logic [RW-1:0] w_rdata, w_head;
    logic [RW-1:0] r_skid [2];
    logic r_sk_wr, r_sk_rd;
    logic [1:0] r_sk_cnt;
    logic [2:0] w_occ;
    logic [DW-1:0] w_desc_head;
`ifdef PACKET_TAGGER_DROP_EN
    logic [PW-1:0] r_beats;
    logic [31:0] r_drop_cnt;
    logic w_drop, w_over;
`endif

    assign w_data_full  = (r_wr_ptr - r_rd_ptr) == PW'(DATA_DEPTH);
    assign w_desc_full  = (r_dwr - r_drd) == DPW'(DESC_DEPTH);
    assign w_desc_empty = r_dwr == r_drd;

`ifdef PACKET_TAGGER_DROP_EN
    assign in_TREADY = r_run & ((r_state == ST_DISCARD) |
                                (~w_data_full & ~w_desc_full));
    assign w_over = r_beats == PW'(MAX_BEATS);
    assign drop_count = r_drop_cnt;
`else
    assign in_TREADY = r_run & ~w_data_full & ~w_desc_full;
`endif

    assign w_beat  = in_TVALID & in_TREADY;
    assign w_inc   = (COUNT_BYTES != 0) ? popcount(128'(in_TKEEP)) : 8'd1;
    assign w_base  = (r_state == ST_HEAD) ? '0 : r_len;
    assign w_sum   = LW'(w_base) + LW'(w_inc);
    assign w_len_nx = (w_sum > LW'(LEN_MAX)) ? LEN_MAX : w_sum[TUSER_WIDTH-1:0];
    assign w_id_nx = (r_state == ST_HEAD) ? in_TDATA[ID_LSB +: TID_WIDTH] : r_id;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= ST_HEAD;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_we   = 1'b0;
        w_push = 1'b0;
`ifdef PACKET_TAGGER_DROP_EN
        w_drop = 1'b0;
`endif
        unique case (r_state)
            ST_HEAD: if (w_beat) begin
                w_we   = 1'b1;
                w_push = in_TLAST;
                w_state_nx = in_TLAST ? ST_HEAD : ST_BODY;
            end
            ST_BODY: if (w_beat) begin
`ifdef PACKET_TAGGER_DROP_EN
                if (w_over) begin
                    w_drop = in_TLAST;
                    w_state_nx = in_TLAST ? ST_HEAD : ST_DISCARD;
                end else
`endif
                begin
                    w_we   = 1'b1;
                    w_push = in_TLAST;
                    w_state_nx = in_TLAST ? ST_HEAD : ST_BODY;
                end
            end
`ifdef PACKET_TAGGER_DROP_EN
            ST_DISCARD: if (w_beat && in_TLAST) begin
                w_drop = 1'b1;
                w_state_nx = ST_HEAD;
            end
`endif
            default: w_state_nx = ST_HEAD;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_run    <= 1'b0;
            r_wr_ptr <= '0;
            r_commit <= '0;
            r_id     <= '0;
            r_len    <= '0;
            r_dwr    <= '0;
`ifdef PACKET_TAGGER_DROP_EN
            r_beats    <= '0;
            r_drop_cnt <= '0;
`endif
        end else begin
            r_run <= 1'b1;
            if (w_we)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_push) r_commit <= r_wr_ptr + 1'b1;
            if (w_push) r_dwr    <= r_dwr + 1'b1;
            if (w_beat) begin
                r_id  <= w_id_nx;
                r_len <= w_len_nx;
            end
`ifdef PACKET_TAGGER_DROP_EN
            if (w_beat) r_beats <= (r_state == ST_HEAD) ? PW'(1) : r_beats + 1'b1;
            if (w_drop) begin
                r_wr_ptr   <= r_commit;
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_push) r_desc[r_dwr[DAW-1:0]] <= {w_id_nx, w_len_nx};
    end

    packet_tagger_ram #(.WIDTH(RW), .DEPTH(DATA_DEPTH)) u_ram (
        .i_clk   (ap_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({in_TDATA, in_TDEST, in_TKEEP, in_TLAST}),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Skid slots are reserved at issue so in-flight reads always land.
    assign w_pop   = out_TVALID & out_TREADY;
    assign w_pop_desc = w_pop & out_TLAST;
    assign w_occ   = {1'b0, r_sk_cnt} + {2'b0, r_rd_vld};
    assign w_issue = ~w_desc_empty & (r_rd_ptr != r_commit) &
                     (w_occ < (3'd2 + {2'b0, w_pop}));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd_ptr <= '0;
            r_rd_vld <= 1'b0;
            r_drd    <= '0;
            r_sk_wr  <= 1'b0;
            r_sk_rd  <= 1'b0;
            r_sk_cnt <= '0;
            for (int i = 0; i < 2; i++) r_skid[i] <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_pop_desc) r_drd <= r_drd + 1'b1;
            if (r_rd_vld) begin
                r_skid[r_sk_wr] <= w_rdata;
                r_sk_wr <= ~r_sk_wr;
            end
            if (w_pop) r_sk_rd <= ~r_sk_rd;
            r_sk_cnt <= r_sk_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
        end
    end

    assign out_TVALID  = r_sk_cnt != 2'd0;
    assign w_head      = out_TVALID ? r_skid[r_sk_rd] : '0;
    assign w_desc_head = out_TVALID ? r_desc[r_drd[DAW-1:0]] : '0;
    assign {out_TDATA, out_TDEST, out_TKEEP, out_TLAST} = w_head;
    assign {out_TID, out_TUSER} = w_desc_head;

endmodule

// File: tb/tb_packet_tagger.sv
// Scoreboard bench for packet_tagger: beat-mode and byte-mode instances.
// Drop scenario runs only when PACKET_TAGGER_DROP_EN is defined.
module tb_packet_tagger;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] dst;
        logic [7:0]  k;
        logic        l;
        logic [15:0] id;
        logic [15:0] len;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] a_data, a_odata, b_data, b_odata;
    logic [15:0] a_dest, a_odest, b_dest, b_odest;
    logic [7:0]  a_keep, a_okeep, b_keep, b_okeep;
    logic a_last, a_valid, a_ready, a_olast, a_ovalid, a_oready;
    logic b_last, b_valid, b_ready, b_olast, b_ovalid, b_oready;
    logic [15:0] a_otid, a_ouser, b_otid, b_ouser;
`ifdef PACKET_TAGGER_DROP_EN
    logic [31:0] a_drops, b_drops;
`endif

    beat_t exp0[$];
    beat_t exp1[$];
    int total = 0;
    int bad = 0;

    packet_tagger #(
        .DATA_DEPTH(16), .DESC_DEPTH(4), .COUNT_BYTES(0), .MAX_BEATS(4)
    ) u0 (
        .ap_clk(clk), .ap_rst(rst),
`ifdef PACKET_TAGGER_DROP_EN
        .drop_count(a_drops),
`endif
        .in_TDATA(a_data), .in_TDEST(a_dest), .in_TKEEP(a_keep),
        .in_TLAST(a_last), .in_TVALID(a_valid), .in_TREADY(a_ready),
        .out_TDATA(a_odata), .out_TDEST(a_odest), .out_TKEEP(a_okeep),
        .out_TLAST(a_olast), .out_TVALID(a_ovalid), .out_TREADY(a_oready),
        .out_TID(a_otid), .out_TUSER(a_ouser)
    );

    packet_tagger #(
        .DATA_DEPTH(16), .DESC_DEPTH(4), .COUNT_BYTES(1), .MAX_BEATS(16)
    ) u1 (
        .ap_clk(clk), .ap_rst(rst),
`ifdef PACKET_TAGGER_DROP_EN
        .drop_count(b_drops),
`endif
        .in_TDATA(b_data), .in_TDEST(b_dest), .in_TKEEP(b_keep),
        .in_TLAST(b_last), .in_TVALID(b_valid), .in_TREADY(b_ready),
        .out_TDATA(b_odata), .out_TDEST(b_odest), .out_TKEEP(b_okeep),
        .out_TLAST(b_olast), .out_TVALID(b_ovalid), .out_TREADY(b_oready),
        .out_TID(b_otid), .out_TUSER(b_ouser)
    );

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && a_ovalid && a_oready) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++;
                    $display("FAIL u0_beat unexpected: id=%h len=%0d required no beat",
                             a_otid, a_ouser);
                end else begin
                    e = exp0.pop_front();
                    if ({a_odata, a_odest, a_okeep, a_olast, a_otid, a_ouser} !== e) begin
                        bad++;
                        $display("FAIL u0_beat: got d=%h dst=%h k=%h l=%b id=%h len=%0d required d=%h dst=%h k=%h l=%b id=%h len=%0d",
                                 a_odata, a_odest, a_okeep, a_olast, a_otid, a_ouser,
                                 e.d, e.dst, e.k, e.l, e.id, e.len);
                    end
                end
            end
            if (!rst && b_ovalid && b_oready) begin
                total++;
                if (exp1.size() == 0) begin
                    bad++;
                    $display("FAIL u1_beat unexpected: id=%h len=%0d required no beat",
                             b_otid, b_ouser);
                end else begin
                    e = exp1.pop_front();
                    if ({b_odata, b_odest, b_okeep, b_olast, b_otid, b_ouser} !== e) begin
                        bad++;
                        $display("FAIL u1_beat: got d=%h k=%h l=%b id=%h len=%0d required d=%h k=%h l=%b id=%h len=%0d",
                                 b_odata, b_okeep, b_olast, b_otid, b_ouser,
                                 e.d, e.k, e.l, e.id, e.len);
                    end
                end
            end
        end
    endtask

    task automatic send0(input int n, input logic [15:0] id,
                         input bit last, input bit keep_it);
        beat_t b;
        int w;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            if (i == 0) b.d[39:24] = id;
            b.dst = 16'($urandom);
            b.k   = 8'($urandom);
            b.l   = last && (i == n - 1);
            b.id  = id;
            b.len = 16'(n);
            if (keep_it) exp0.push_back(b);
            a_data = b.d; a_dest = b.dst; a_keep = b.k;
            a_last = b.l; a_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!a_ready && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (!a_ready) begin
                total++; bad++;
                $display("FAIL u0_in_ready_timeout: in_TREADY=%b required 1", a_ready);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            bad++;
            $display("FAIL drain: left0=%0d left1=%0d required 0 0",
                     exp0.size(), exp1.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_ovalid, a_odata, a_odest, a_okeep, a_olast, a_otid, a_ouser, a_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: vld=%b d=%h id=%h len=%h rdy=%b required all 0",
                     a_ovalid, a_odata, a_otid, a_ouser, a_ready);
        end
`ifdef PACKET_TAGGER_DROP_EN
        total++;
        if (a_drops !== 32'd0) begin
            bad++;
            $display("FAIL reset_drop_count: got %0d required 0", a_drops);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({a_ready, b_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_reset: got %b%b required 11", a_ready, b_ready);
        end
    endtask

    task automatic test_basic();
        a_oready = 1'b1;
        send0(3, 16'h00AB, 1'b1, 1'b1);
        total++;
        if (a_ovalid !== 1'b0) begin
            bad++;
            $display("FAIL latency_T0: out_TVALID=%b required 0", a_ovalid);
        end
        @(posedge clk); #1;
        total++;
        if (a_ovalid !== 1'b0) begin
            bad++;
            $display("FAIL latency_T1: out_TVALID=%b required 0", a_ovalid);
        end
        @(posedge clk); #1;
        total++;
        if (a_ovalid !== 1'b1) begin
            bad++;
            $display("FAIL latency_T2: out_TVALID=%b required 1", a_ovalid);
        end
        wait_drain();
    endtask

    task automatic test_bytes();
        beat_t b;
        logic [7:0] keeps [2];
        int w;
        keeps[0] = 8'hFF;
        keeps[1] = 8'h0F;
        b_oready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b.d = {$urandom, $urandom};
            if (i == 0) b.d[39:24] = 16'h5A5A;
            b.dst = 16'($urandom);
            b.k = keeps[i];
            b.l = (i == 1);
            b.id = 16'h5A5A;
            b.len = 16'd12;
            exp1.push_back(b);
            b_data = b.d; b_dest = b.dst; b_keep = b.k;
            b_last = b.l; b_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!b_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!b_ready) begin
                total++; bad++;
                $display("FAIL u1_in_ready_timeout: in_TREADY=%b required 1", b_ready);
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        b_last = 1'b0;
        wait_drain();
    endtask

    task automatic test_desc_full();
        a_oready = 1'b0;
        for (int i = 0; i < 4; i++) send0(1, 16'(16'h0100 + i), 1'b1, 1'b1);
        total++;
        if (a_ready !== 1'b0) begin
            bad++;
            $display("FAIL desc_full_ready: in_TREADY=%b required 0", a_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (a_ready !== 1'b0) begin
            bad++;
            $display("FAIL desc_full_hold: in_TREADY=%b required 0", a_ready);
        end
        a_oready = 1'b1;
        send0(1, 16'h0104, 1'b1, 1'b1);
        send0(1, 16'h0105, 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_wrap();
        bit done = 1'b0;
        fork
            begin
                send0(10, 16'h1111, 1'b1, 1'b1);
                send0(10, 16'h2222, 1'b1, 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    a_oready = ($urandom_range(0, 2) == 0);
                end
            end
        join
        a_oready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        a_oready = 1'b0;
        send0(2, 16'h0B01, 1'b1, 1'b1);
        send0(1, 16'h0B02, 1'b1, 1'b1);
        send0(3, 16'h0B03, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        a_oready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (a_ovalid) cnt++;
        end
        total++;
        if (cnt != 6) begin
            bad++;
            $display("FAIL back_to_back: valid_cycles=%0d required 6", cnt);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

`ifdef PACKET_TAGGER_DROP_EN
    task automatic test_drop();
        a_oready = 1'b1;
        send0(6, 16'hDEAD, 1'b1, 1'b0);
        send0(2, 16'hBEEF, 1'b1, 1'b1);
        wait_drain();
        total++;
        if (a_drops !== 32'd1) begin
            bad++;
            $display("FAIL drop_count: got %0d required 1", a_drops);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int seen = 0;
        a_oready = 1'b1;
        send0(2, 16'h7777, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({a_ovalid, a_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid: vld=%b rdy=%b required 0 0", a_ovalid, a_ready);
        end
`ifdef PACKET_TAGGER_DROP_EN
        total++;
        if (a_drops !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_drops: got %0d required 0", a_drops);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        send0(3, 16'h0C0C, 1'b1, 1'b1);
        wait_drain();
        repeat (10) begin
            @(negedge clk);
            if (a_ovalid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_extra: extra_valid_cycles=%0d required 0", seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        a_data = '0; a_dest = '0; a_keep = '0; a_last = 1'b0;
        a_valid = 1'b0; a_oready = 1'b0;
        b_data = '0; b_dest = '0; b_keep = '0; b_last = 1'b0;
        b_valid = 1'b0; b_oready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_bytes();
        test_desc_full();
        test_wrap();
        test_back_to_back();
`ifdef PACKET_TAGGER_DROP_EN
        test_drop();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
